// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and default threshold helpers for sync_fifo
package fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int af_default(input int addr);
    return (1 << addr) - 4;
  endfunction
  function automatic int ae_default();
    return 4;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, one write port, one registered read port with enable
module sync_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, thresholds, sticky errors and optional FWFT output
module sync_fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR       = 6,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_LEVEL   = af_default(ADDR),
  parameter int AE_LEVEL   = ae_default()
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR:0]         count
);
  localparam bit FW = FWFT == FIFO_FWFT;
  localparam logic [ADDR:0] MSB = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF = AF_LEVEL[ADDR:0];
  localparam logic [ADDR:0] AE = AE_LEVEL[ADDR:0];
  logic [ADDR:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d, valid_q, valid_d, byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d, ram_rdata;
  logic wr_acc, rd_acc, load, bypass, ram_re;
  logic [ADDR-1:0] ram_raddr;
  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q + (ADDR+1)'(wr_acc);
    rd_ptr_d   = rd_ptr_q + (ADDR+1)'(rd_acc);
    count_d    = wr_ptr_d - rd_ptr_d;
    full_d     = (wr_ptr_d ^ rd_ptr_d) == MSB;
    empty_d    = count_d == '0;
    af_d       = count_d >= AF;
    ae_d       = count_d <= AE;
    ovf_d      = ovf_q || (wr_en && full_q);
    unf_d      = unf_q || (rd_en && empty_q);
    // FWFT refills the head register on a pop, or on a write into an empty FIFO;
    // a head that is being written this very cycle bypasses the RAM
    load       = FW && (rd_acc || (empty_q && wr_acc));
    bypass     = load && wr_acc && rd_ptr_d == wr_ptr_q;
    ram_re     = FW ? load && !bypass : rd_acc;
    ram_raddr  = FW ? rd_ptr_d[ADDR-1:0] : rd_ptr_q[ADDR-1:0];
    byp_d      = load ? bypass : byp_q;
    byp_data_d = bypass ? wdata : byp_data_q;
    valid_d    = FW ? !empty_d : rd_acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      valid_q    <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      af_q       <= af_d;
      empty_q    <= empty_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      valid_q    <= valid_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end
  sync_fifo_ram #(.DW(DATA_WIDTH), .AW(ADDR)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR-1:0]),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );
  assign rdata        = byp_q ? byp_data_q : ram_rdata;
  assign rd_valid     = valid_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign count        = count_q;
endmodule
